// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit with architectural HI/LO.
// One operation takes WIDTH RUN cycles plus one FIX cycle. RUN does a
// shift-add multiply or a restoring divide on operand magnitudes. FIX applies
// sign correction and selects the special-case results, and HI/LO are
// committed at the end of FIX.
// Optional feature: define MULDIV_SIGNED_EN to enable signed MULT/DIV (op[1]);
// without it every operation is unsigned and the latency is the same.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int               CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef MULDIV_SIGNED_EN
    localparam logic SIGNED_EN = 1'b1;
`else
    localparam logic SIGNED_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // Control state (reset)
    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    // Operation context and iteration datapath (not reset)
    logic             is_div_q;
    logic             neg_res_q;   // negate product or quotient in FIX
    logic             neg_rem_q;   // negate remainder in FIX
    logic             div_zero_q;
    logic             ovf_q;
    logic [WIDTH-1:0] a_raw_q;     // original dividend, returned as HI on divide-by-zero
    logic [WIDTH-1:0] opnd_q;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0] p_hi_q;      // product upper half / partial remainder
    logic [WIDTH-1:0] p_lo_q;      // multiplier bits / dividend bits becoming quotient

    // Request decode and operand magnitude preparation
    logic             start_ok;
    logic             signed_req;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // Accept a start only from IDLE and only if abort is not competing for it
    always_comb begin
        start_ok   = (state_q == S_IDLE) && start && !abort;
        signed_req = SIGNED_EN & op[1];
        a_neg      = signed_req & a[WIDTH-1];
        b_neg      = signed_req & b[WIDTH-1];
        a_mag      = a_neg ? (WIDTH'(0) - a) : a;
        b_mag      = b_neg ? (WIDTH'(0) - b) : b;
    end

    // One radix-2 iteration step
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_trial;
    logic           div_ok;

    // Add-if-set for multiply; trial subtraction for restoring divide
    always_comb begin
        mul_sum   = {1'b0, p_hi_q} + ({1'b0, opnd_q} & {(WIDTH+1){p_lo_q[0]}});
        div_shift = {p_hi_q, p_lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        div_ok    = !div_trial[WIDTH];
    end

    // FIX-cycle result selection and sign correction
    logic [2*WIDTH-1:0] mul_mag;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   quo_res;
    logic [WIDTH-1:0]   rem_res;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // Divide-by-zero and signed overflow override the iterated result
    always_comb begin
        mul_mag = {p_hi_q, p_lo_q};
        mul_res = neg_res_q ? ((2*WIDTH)'(0) - mul_mag) : mul_mag;
        quo_res = neg_res_q ? (WIDTH'(0) - p_lo_q) : p_lo_q;
        rem_res = neg_rem_q ? (WIDTH'(0) - p_hi_q) : p_hi_q;
        if (div_zero_q) begin
            res_lo = {WIDTH{1'b1}};
            res_hi = a_raw_q;
        end else if (ovf_q) begin
            res_lo = MOST_NEG;
            res_hi = '0;
        end else if (is_div_q) begin
            res_lo = quo_res;
            res_hi = rem_res;
        end else begin
            res_lo = mul_res[WIDTH-1:0];
            res_hi = mul_res[2*WIDTH-1:WIDTH];
        end
    end

    // Next-state, iteration counter, HI/LO writes and done pulse
    always_comb begin
        // NOTE: every signal written here gets a default first so that no
        // path through the case statement leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                if (!abort) begin
                    hi_d   = res_hi;
                    lo_d   = res_lo;
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Operand capture on an accepted start, one iteration per RUN cycle
    always_ff @(posedge clk) begin
        // NOTE: the datapath is deliberately not reset; it is always loaded
        // by an accepted start before it is used, and it reaches the outputs
        // only through the reset HI/LO registers.
        if (start_ok) begin
            is_div_q   <= op[0];
            neg_res_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            div_zero_q <= op[0] && (b == '0);
            ovf_q      <= op[0] && signed_req && (a == MOST_NEG) && (b == {WIDTH{1'b1}});
            a_raw_q    <= a;
            p_hi_q     <= '0;
            if (op[0]) begin
                opnd_q <= b_mag;
                p_lo_q <= a_mag;
            end else begin
                opnd_q <= a_mag;
                p_lo_q <= b_mag;
            end
        end else if (state_q == S_RUN) begin
            if (is_div_q) begin
                p_hi_q <= div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
                p_lo_q <= {p_lo_q[WIDTH-2:0], div_ok};
            end else begin
                {p_hi_q, p_lo_q} <= {mul_sum, p_lo_q[WIDTH-1:1]};
            end
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit (WIDTH=32): table-driven operation vectors plus
// hand-written sequences for reset, MTHI/MTLO, abort, ignored start and
// mid-operation reset. Expectations follow MULDIV_SIGNED_EN when it is defined.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         abort;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .abort (abort),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input string name, input logic [1:0] vop,
                           input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic [W-1:0] vhi, input logic [W-1:0] vlo);
        vecs[idx].name = name;
        vecs[idx].op   = vop;
        vecs[idx].a    = va;
        vecs[idx].b    = vb;
        vecs[idx].hi   = vhi;
        vecs[idx].lo   = vlo;
    endtask

    // Issue one operation, scramble operands after acceptance, count busy
    // cycles and check the committed result and the single done pulse.
    task automatic run_vec(input vec_t v);
        int n;
        @(negedge clk);
        start = 1'b1;
        op    = v.op;
        a     = v.a;
        b     = v.b;
        @(negedge clk);
        start = 1'b0;
        a     = ~v.a;
        b     = v.b + 32'd1;
        n     = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({v.name, "_busy_cycles"}, 64'(n), 64'(W + 1));
        check({v.name, "_done"}, 64'(done), 64'd1);
        check({v.name, "_hi"}, 64'(hi), 64'(v.hi));
        check({v.name, "_lo"}, 64'(lo), 64'(v.lo));
        @(negedge clk);
        check({v.name, "_done_drop"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n;

        set_vec(0,  "multu_max",   2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        set_vec(1,  "multu_carry", 2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780);
        set_vec(2,  "divu_small",  2'b01, 32'd100,      32'd7,        32'd2,        32'd14);
        set_vec(3,  "divu_zero",   2'b01, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF);
        set_vec(4,  "multu_zero",  2'b00, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000);
        set_vec(5,  "divu_by_one", 2'b01, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF);
        set_vec(6,  "div_zero_s",  2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);
`ifdef MULDIV_SIGNED_EN
        set_vec(7,  "div_neg7_2",  2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        set_vec(8,  "div_ovf",     2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        set_vec(9,  "mult_neg2_3", 2'b10, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
        set_vec(10, "div_7_neg2",  2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
`else
        set_vec(7,  "div_neg7_2",  2'b11, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC);
        set_vec(8,  "div_ovf",     2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);
        set_vec(9,  "mult_neg2_3", 2'b10, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA);
        set_vec(10, "div_7_neg2",  2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000007, 32'h00000000);
`endif

        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        abort = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);

        // MTHI then MTLO in IDLE
        hi_we = 1'b1;
        wdata = 32'hA5A5A5A5;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_hi", 64'(hi), 64'hA5A5A5A5);
        check("mthi_lo", 64'(lo), 64'd0);
        lo_we = 1'b1;
        wdata = 32'h5A5A5A5A;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h5A5A5A5A);
        check("mtlo_hi", 64'(hi), 64'hA5A5A5A5);

        // Abort at busy cycle 10; MTLO attempted at busy cycle 3 is ignored
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd3;
        b     = 32'd5;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            if (k == 3) begin
                lo_we = 1'b1;
                wdata = 32'hDEADBEEF;
            end
            @(negedge clk);
            if (k == 3) begin
                lo_we = 1'b0;
                check("busy_mtlo_ignored", 64'(lo), 64'h5A5A5A5A);
            end
        end
        check("abort_busy_before", 64'(busy), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hi), 64'hA5A5A5A5);
        check("abort_lo", 64'(lo), 64'h5A5A5A5A);
        @(negedge clk);
        check("abort_done_later", 64'(done), 64'd0);

        // Abort together with start in IDLE drops the start
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_wins_busy", 64'(busy), 64'd0);

        // Start with MTHI in the same cycle, plus an ignored start at cycle 5
        start = 1'b1;
        hi_we = 1'b1;
        wdata = 32'hFFFF0000;
        op    = 2'b00;
        a     = 32'd3;
        b     = 32'd5;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        check("start_we_busy", 64'(busy), 64'd1);
        check("start_we_hi", 64'(hi), 64'hA5A5A5A5);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd100;
        b     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        n = 5;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("ign_start_cycles", 64'(n), 64'(W + 1));
        check("ign_start_done", 64'(done), 64'd1);
        check("ign_start_hi", 64'(hi), 64'd0);
        check("ign_start_lo", 64'(lo), 64'd15);
        @(negedge clk);

        // Abort during the FIX cycle suppresses the commit
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd100;
        b     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (W) @(negedge clk);
        check("fix_busy", 64'(busy), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("fix_abort_busy", 64'(busy), 64'd0);
        check("fix_abort_done", 64'(done), 64'd0);
        check("fix_abort_hi", 64'(hi), 64'd0);
        check("fix_abort_lo", 64'(lo), 64'd15);

        // Vector table
        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i]);
        end

        // Reset at busy cycle 20, then a fresh operation
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        a     = 32'hFFFFFFFF;
        b     = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("rst_mid_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_hi", 64'(hi), 64'd0);
        check("rst_mid_lo", 64'(lo), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
